// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard.
// Clocked writes (highest port wins), combinational reads with optional write bypass.
module regfile_mp #(
  parameter int NUM_REGS = 64,
  parameter int DATA_W   = 32,
  parameter int NUM_RD   = 6,
  parameter int NUM_WR   = 3,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR-1:0]        alloc_en,
  input  logic [NUM_WR*AW-1:0]     alloc_addr,
  output logic                     wr_conflict
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                wr_conflict_q;
  logic                wr_conflict_d;

  logic [AW-1:0]       wa [NUM_WR];
  logic [DATA_W-1:0]   wd [NUM_WR];
  logic [AW-1:0]       aa [NUM_WR];

  genvar gi;

  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr_unpack
      assign wa[gi] = wr_addr[gi*AW +: AW];
      assign wd[gi] = wr_data[gi*DATA_W +: DATA_W];
      assign aa[gi] = alloc_addr[gi*AW +: AW];
    end
  endgenerate

  // Later ports overwrite earlier ones, so the highest-index write wins.
  // Allocates are applied after write clears so a same-edge set wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wa[j] != '0)) begin
        regs_d[wa[j]] = wd[j];
        busy_d[wa[j]] = 1'b0;
      end
    end
    for (int j = 0; j < NUM_WR; j++) begin
      if (alloc_en[j] && (aa[j] != '0)) begin
        busy_d[aa[j]] = 1'b1;
      end
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    wr_conflict_d = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int k = j + 1; k < NUM_WR; k++) begin
        if (wr_en[j] && wr_en[k] && (wa[j] == wa[k]) && (wa[j] != '0)) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          regs_q[gi] <= '0;
        end else begin
          regs_q[gi] <= regs_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict = wr_conflict_q;

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]     ra;
      logic              hit;
      logic              use_fwd;
      logic [DATA_W-1:0] fwd;

      assign ra = rd_addr[gi*AW +: AW];

      always_comb begin
        hit = 1'b0;
        fwd = '0;
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wa[j] == ra) && (ra != '0)) begin
            hit = 1'b1;
            fwd = wd[j];
          end
        end
      end

      // Forwarding is suppressed in reset so reads return zero immediately.
      assign use_fwd = (BYPASS != 0) && hit && !rst;
      assign rd_data[gi*DATA_W +: DATA_W] = use_fwd ? fwd : regs_q[ra];
      assign rd_busy[gi] = busy_q[ra] & ~use_fwd;
    end
  endgenerate

endmodule
